// File: rtl/inj_scan_ctrl_if.sv
// Bus between the config bank / front end and the injection scan sequencer.
// Master drives the scan controls and COMP; slave (the sequencer) drives pulse and status.
interface inj_scan_ctrl_if #(
    parameter int CNT_W  = 8,
    parameter int TIME_W = 16
);
    logic              start;
    logic              abort;
    logic [CNT_W-1:0]  num_inj;
    logic [TIME_W-1:0] inj_width;
    logic [TIME_W-1:0] inj_period;
    logic              comp;
    logic              inj_out;
    logic              busy;
    logic              done;
    logic              hit;
    logic [CNT_W-1:0]  hit_cnt;

    modport master (
        output start, abort, num_inj, inj_width, inj_period, comp,
        input  inj_out, busy, done, hit, hit_cnt
    );

    modport slave (
        input  start, abort, num_inj, inj_width, inj_period, comp,
        output inj_out, busy, done, hit, hit_cnt
    );
endinterface

// File: rtl/inj_scan_ctrl.sv
// Injection pulse train sequencer with synchronized comparator hit counting per window.
// Outputs are registered: INJ_OUT rises the cycle after START; ABORT takes effect next cycle.
module inj_scan_ctrl #(
    parameter int CNT_W       = 8,
    parameter int TIME_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_b,
    inj_scan_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW, FINISH} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   comp_prev;
    logic                   comp_rise;
    logic                   hit_flag;
    logic [TIME_W-1:0]      wh_q;
    logic [TIME_W-1:0]      wl_q;
    logic [TIME_W-1:0]      tcnt;
    logic [CNT_W-1:0]       rem;
    logic [TIME_W-1:0]      wh_in;
    logic [TIME_W-1:0]      wl_in;
    logic                   inj_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   hit_q;
    logic [CNT_W-1:0]       hit_cnt_q;

    always_comb begin
        wh_in = (bus.inj_width == '0) ? TIME_W'(1) : bus.inj_width;
        wl_in = (bus.inj_period > wh_in) ? (bus.inj_period - wh_in) : TIME_W'(1);
    end

    assign comp_rise = sync[SYNC_STAGES-1] & ~comp_prev;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sync      <= '0;
            comp_prev <= 1'b0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], bus.comp};
            comp_prev <= sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= IDLE;
            hit_flag  <= 1'b0;
            wh_q      <= TIME_W'(1);
            wl_q      <= TIME_W'(1);
            tcnt      <= '0;
            rem       <= '0;
            inj_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hit_q     <= 1'b0;
            hit_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            hit_q  <= 1'b0;
            if (bus.abort) begin
                // Partial count is kept; the open window is dropped.
                state    <= IDLE;
                inj_q    <= 1'b0;
                busy_q   <= 1'b0;
                hit_flag <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (bus.start) begin
                            wh_q      <= wh_in;
                            wl_q      <= wl_in;
                            rem       <= bus.num_inj;
                            tcnt      <= wh_in - TIME_W'(1);
                            hit_cnt_q <= '0;
                            hit_flag  <= 1'b0;
                            if (bus.num_inj != '0) begin
                                state  <= HIGH;
                                inj_q  <= 1'b1;
                                busy_q <= 1'b1;
                            end else begin
                                state  <= FINISH;
                                done_q <= 1'b1;
                            end
                        end
                    end
                    HIGH: begin
                        if (comp_rise) hit_flag <= 1'b1;
                        if (tcnt == '0) begin
                            state <= LOW;
                            inj_q <= 1'b0;
                            tcnt  <= wl_q - TIME_W'(1);
                        end else begin
                            tcnt <= tcnt - TIME_W'(1);
                        end
                    end
                    LOW: begin
                        if (tcnt == '0) begin
                            // An edge on the closing cycle still belongs to this window.
                            hit_flag <= 1'b0;
                            if (hit_flag | comp_rise) begin
                                hit_q     <= 1'b1;
                                hit_cnt_q <= hit_cnt_q + CNT_W'(1);
                            end
                            rem <= rem - CNT_W'(1);
                            if (rem == CNT_W'(1)) begin
                                state  <= FINISH;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                            end else begin
                                state <= HIGH;
                                inj_q <= 1'b1;
                                tcnt  <= wh_q - TIME_W'(1);
                            end
                        end else begin
                            if (comp_rise) hit_flag <= 1'b1;
                            tcnt <= tcnt - TIME_W'(1);
                        end
                    end
                    FINISH: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.inj_out = inj_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.hit     = hit_q;
    assign bus.hit_cnt = hit_cnt_q;
endmodule

// File: tb/tb_inj_scan_ctrl.sv
// Randomized and directed bench for inj_scan_ctrl against a window-arithmetic reference model.
module tb_inj_scan_ctrl;
    localparam int SYNC = 2;
    localparam int HMAX = 16384;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    inj_scan_ctrl_if #(.CNT_W(8), .TIME_W(16)) bus ();
    inj_scan_ctrl #(.CNT_W(8), .TIME_W(16), .SYNC_STAGES(SYNC)) dut (
        .clk  (clk),
        .rst_b(rst_b),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int g       = 0;
    bit comp_hist [HMAX];
    bit chk_en  = 1'b0;

    int exp_inj = 0, exp_busy = 0, exp_done = 0, exp_hit = 0, exp_cnt = 0;
    bit sc_on = 1'b0;
    int sc_t0 = 0, sc_n = 0, sc_wh = 1, sc_p = 2, sc_ka = -1;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_tests++;
        if (act !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, g);
        end
    endtask

    // Edge visible to the window logic in the cycle after edge a: sync output vs its previous value.
    function automatic bit edge_at(int a);
        if (a < SYNC) return 1'b0;
        return comp_hist[a-SYNC+1] && !comp_hist[a-SYNC];
    endfunction

    function automatic bit win_hit(int w);
        bit h = 1'b0;
        for (int k = w*sc_p; k < (w+1)*sc_p; k++)
            if (edge_at(sc_t0 + k)) h = 1'b1;
        return h;
    endfunction

    function automatic int hits_closed(int upto);
        int c = 0;
        for (int w = 0; w < sc_n; w++)
            if ((w+1)*sc_p <= upto && win_hit(w)) c++;
        return c;
    endfunction

    task automatic model_update();
        int k;
        int lim;
        exp_inj = 0; exp_busy = 0; exp_done = 0; exp_hit = 0;
        if (!sc_on) return;
        k   = g - sc_t0;
        lim = (sc_ka >= 0) ? sc_ka - sc_t0 : (1 << 30);
        if (k < 0) return;
        if (k >= lim) begin
            exp_cnt = hits_closed(lim - 1);
        end else begin
            exp_cnt = hits_closed(k);
            if (k < sc_n*sc_p) begin
                exp_inj  = ((k % sc_p) < sc_wh) ? 1 : 0;
                exp_busy = 1;
            end
            if (k == sc_n*sc_p) exp_done = 1;
            if (k > 0 && (k % sc_p) == 0 && k <= sc_n*sc_p) exp_hit = win_hit(k/sc_p - 1) ? 1 : 0;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("inj_out", 32'(bus.inj_out), exp_inj);
            check("busy",    32'(bus.busy),    exp_busy);
            check("done",    32'(bus.done),    exp_done);
            check("hit",     32'(bus.hit),     exp_hit);
            check("hit_cnt", 32'(bus.hit_cnt), exp_cnt);
        end
    end

    task automatic step();
        @(posedge clk);
        g++;
        if (g >= HMAX - 1) begin
            $display("FAIL cycle_budget: got %0d cycles expected < %0d", g, HMAX - 1);
            $fatal(1, "cycle budget exhausted");
        end
        comp_hist[g] = bus.comp;
        #1;
        model_update();
    endtask

    function automatic bit comp_pat(int mode, int k, int p, int wh);
        case (mode)
            1:       return ((k % p) >= wh + 1) && ((k % p) <= wh + 3);
            2:       return (k == 1) || (k == 2) || (k == 5) || (k == 6) || (k >= 8 && k <= 12);
            3:       return ($urandom_range(0, 3) == 0);
            default: return 1'b0;
        endcase
    endfunction

    task automatic idle(input int m, input bit rnd);
        for (int i = 0; i < m; i++) begin
            bus.start = 1'b0;
            bus.abort = 1'b0;
            bus.comp  = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
            bus.num_inj = 8'($urandom);
            step();
        end
        bus.comp = 1'b0;
    endtask

    task automatic run_scan(input int n, input int w, input int p, input int mode, input int ka_rel,
                            output int done_k, output int hits, output logic [3:0] pat);
        int wh, wl, pp, len;
        wh = (w == 0) ? 1 : w;
        wl = (p > wh) ? p - wh : 1;
        pp = wh + wl;
        done_k = -1; hits = 0; pat = '0;
        bus.start = 1'b1; bus.abort = 1'b0;
        bus.num_inj = 8'(n); bus.inj_width = 16'(w); bus.inj_period = 16'(p);
        bus.comp = comp_pat(mode, 0, pp, wh);
        sc_on = 1'b1; sc_t0 = g + 1; sc_n = n; sc_wh = wh; sc_p = pp;
        sc_ka = (ka_rel > 0) ? sc_t0 + ka_rel : -1;
        len = n*pp + 3;
        for (int k = 0; k < len; k++) begin
            step();
            if (bus.done === 1'b1 && done_k < 0) done_k = k;
            if (bus.hit === 1'b1) hits++;
            if (k < 4) pat[3-k] = bus.inj_out;
            bus.start = ($urandom_range(0, 7) == 0) && (k + 1 <= n*pp) && (ka_rel <= 0 || k + 1 < ka_rel);
            bus.num_inj = 8'($urandom); bus.inj_width = 16'($urandom); bus.inj_period = 16'($urandom);
            bus.abort = (ka_rel > 0) && (k + 1 == ka_rel);
            bus.comp  = comp_pat(mode, k + 1, pp, wh);
            if (ka_rel > 0 && k + 1 > ka_rel + 2) break;
        end
        bus.start = 1'b0; bus.abort = 1'b0; bus.comp = 1'b0;
    endtask

    initial begin
        int dk, hc;
        logic [3:0] pt;
        bus.start = 1'b0; bus.abort = 1'b0; bus.comp = 1'b0;
        bus.num_inj = '0; bus.inj_width = '0; bus.inj_period = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_inj",  32'(bus.inj_out), 0);
        check("rst_busy", 32'(bus.busy),    0);
        check("rst_done", 32'(bus.done),    0);
        check("rst_hit",  32'(bus.hit),     0);
        check("rst_cnt",  32'(bus.hit_cnt), 0);
        rst_b = 1'b1;
        chk_en = 1'b1;
        idle(4, 1'b0);

        // Reset asserted during the second HIGH cycle.
        bus.start = 1'b1; bus.num_inj = 8'd3; bus.inj_width = 16'd4; bus.inj_period = 16'd10;
        sc_on = 1'b1; sc_t0 = g + 1; sc_n = 3; sc_wh = 4; sc_p = 10; sc_ka = -1;
        step();
        bus.start = 1'b0;
        step();
        check("pre_rst_inj", 32'(bus.inj_out), 1);
        chk_en = 1'b0;
        #1 rst_b = 1'b0;
        #1;
        check("midrst_inj",  32'(bus.inj_out), 0);
        check("midrst_busy", 32'(bus.busy),    0);
        check("midrst_cnt",  32'(bus.hit_cnt), 0);
        sc_on = 1'b0; exp_cnt = 0;
        step(); step();
        #2 rst_b = 1'b1;
        chk_en = 1'b1;
        idle(8, 1'b0);

        run_scan(3, 4, 10, 0, 0, dk, hc, pt);
        check("tp2_done_k", 32'(dk), 30);
        check("tp2_hits",   32'(hc), 0);
        check("tp2_cnt",    32'(bus.hit_cnt), 0);
        idle(3, 1'b0);

        run_scan(3, 4, 10, 1, 0, dk, hc, pt);
        check("tp3_done_k", 32'(dk), 30);
        check("tp3_hits",   32'(hc), 3);
        check("tp3_cnt",    32'(bus.hit_cnt), 3);
        idle(3, 1'b0);

        run_scan(2, 4, 10, 2, 0, dk, hc, pt);
        check("tp4_cnt", 32'(bus.hit_cnt), 1);
        idle(3, 1'b0);

        run_scan(2, 0, 0, 0, 0, dk, hc, pt);
        check("tp5_pat",    32'(pt), 4'b1010);
        check("tp5_done_k", 32'(dk), 4);
        idle(3, 1'b0);

        run_scan(5, 4, 10, 1, 22, dk, hc, pt);
        check("tp6_no_done", 32'(dk), -1);
        check("tp6_cnt",     32'(bus.hit_cnt), 2);
        idle(2, 1'b0);

        // START and ABORT together in IDLE: no scan, count held.
        bus.start = 1'b1; bus.abort = 1'b1; bus.num_inj = 8'd3;
        step();
        bus.start = 1'b0; bus.abort = 1'b0;
        check("sa_busy", 32'(bus.busy),    0);
        check("sa_cnt",  32'(bus.hit_cnt), 2);
        idle(2, 1'b0);

        run_scan(0, 5, 9, 3, 0, dk, hc, pt);
        check("tp6b_done_k", 32'(dk), 0);
        check("tp6b_cnt",    32'(bus.hit_cnt), 0);
        idle(2, 1'b1);

        for (int s = 0; s < 30; s++) begin
            int n, w, p, ka, wh, pp;
            n  = $urandom_range(0, 6);
            w  = $urandom_range(0, 6);
            p  = $urandom_range(0, 14);
            wh = (w == 0) ? 1 : w;
            pp = (p > wh) ? p : wh + 1;
            ka = 0;
            if (n*pp > 2 && $urandom_range(0, 3) == 0) ka = $urandom_range(1, n*pp - 1);
            run_scan(n, w, p, 3, ka, dk, hc, pt);
            idle($urandom_range(0, 4), 1'b1);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/inj_scan_ctrl.md
Name: inj_scan_ctrl

Overview:
- Sequencer for the AFE injection/discriminator path. Generates a programmed train of injection pulses on INJ_OUT and samples the comparator output COMP in a window after each pulse. Counts how many injections produced a hit.
- Sits between the configuration register bank, which supplies START and the scan settings, and the injection/comparator front end. Replaces manual software toggling of the injection line during threshold and gain scans.

Parameters:
- CNT_W, 8, width of NUM_INJ and HIT_CNT.
- TIME_W, 16, width of INJ_WIDTH and INJ_PERIOD, in CLK cycles.
- SYNC_STAGES, 2, number of flip-flops in the COMP synchronizer (minimum 2).

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST_B  in  1  asynchronous active-low reset.
- START  in  1  single-cycle request to begin a scan; honoured only in IDLE.
- ABORT  in  1  stops the scan from any state.
- NUM_INJ  in  CNT_W  number of injections per scan.
- INJ_WIDTH  in  TIME_W  injection high time in cycles.
- INJ_PERIOD  in  TIME_W  injection repetition period in cycles.
- COMP  in  1  asynchronous comparator output.
- INJ_OUT  out  1  injection pulse to the front end.
- BUSY  out  1  high while a scan is running.
- DONE  out  1  one-cycle pulse at normal scan completion.
- HIT  out  1  one-cycle pulse when a window closes with a hit.
- HIT_CNT  out  CNT_W  number of hit windows in the current or last scan.

Behaviour:
- Reset (RST_B=0): state=IDLE; INJ_OUT, BUSY, DONE, HIT=0; HIT_CNT=0; synchronizer stages and hit flag cleared.
- Configuration latch: on START in IDLE, NUM_INJ, INJ_WIDTH and INJ_PERIOD are captured. Changing the inputs during a scan has no effect.
- Effective timing:
  - Wh = max(INJ_WIDTH, 1).
  - Wl = INJ_PERIOD - Wh if INJ_PERIOD > Wh, else Wl = 1.
- State machine: IDLE, HIGH, LOW, FINISH.
  - IDLE: on START with NUM_INJ != 0, clear HIT_CNT, set BUSY=1 and enter HIGH. INJ_OUT=1 from the cycle after START is sampled.
  - IDLE, START with NUM_INJ = 0: clear HIT_CNT, go to FINISH. No pulse is generated.
  - HIGH: INJ_OUT=1 for exactly Wh cycles, then go to LOW.
  - LOW: INJ_OUT=0 for exactly Wl cycles. At the last LOW cycle, evaluate the hit flag. Then decrement the remaining-injection counter; if it is non-zero go to HIGH, otherwise go to FINISH.
  - FINISH: DONE=1 and BUSY=0 for one cycle, then return to IDLE.
  - START while not in IDLE is ignored.
- COMP handling:
  - COMP passes through the SYNC_STAGES synchronizer, then a rising-edge detector.
  - The hit window spans all HIGH and LOW cycles of one injection.
  - A synchronized rising edge inside the window sets the hit flag. Multiple edges in one window still count as one hit.
  - An edge is attributed to the window active in the cycle it is detected. An edge on the first HIGH cycle belongs to the new window.
  - COMP held high across the window start produces no edge, so no hit.
- Hit evaluation at window close: if the flag is set, HIT pulses for one cycle and HIT_CNT increments in that same cycle. The flag is cleared for the next window. HIT_CNT cannot exceed NUM_INJ, so no saturation is needed.
- ABORT: highest priority, from any state. On the next cycle the state is IDLE and INJ_OUT=0, BUSY=0, HIT=0. There is no DONE pulse. HIT_CNT holds its partial value and the current window is not counted.
- START and ABORT in the same IDLE cycle: ABORT wins and the scan does not start.
- HIT_CNT holds after DONE until the next accepted START.
- Total scan length: NUM_INJ*(Wh+Wl) cycles from the first INJ_OUT rise to DONE, with DONE asserted the cycle after the final LOW cycle.

Test Plan:
- Reset during a scan (RST_B low while in HIGH) -> INJ_OUT, BUSY, HIT_CNT all 0 immediately; after release, IDLE with no pulses.
- NUM_INJ=3, INJ_WIDTH=4, INJ_PERIOD=10, COMP=0 -> three INJ_OUT high pulses of 4 cycles, spaced 10 cycles; DONE 30 cycles after the first rise; HIT_CNT=0; HIT never pulses.
- Same configuration, one COMP 0->1->0 pulse (3 cycles wide) in each LOW phase -> HIT pulses 3 times, each at a window end; HIT_CNT=3 at DONE.
- NUM_INJ=2; two COMP pulses in window 1, none in window 2, COMP held high across the window-2 start -> HIT_CNT=1.
- INJ_WIDTH=0, INJ_PERIOD=0, NUM_INJ=2 -> INJ_OUT pattern 1,0,1,0 (Wh=1, Wl=1); DONE on the next cycle.
- NUM_INJ=5, ABORT during the 3rd HIGH phase, after 2 hits -> INJ_OUT=0 next cycle, no DONE, HIT_CNT=2. A following START with NUM_INJ=0 -> DONE 1 cycle later and HIT_CNT=0.
